// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Vedic multiplier: FSM state encoding,
// digit width and the per-operand digit count helper.
package vedic_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DIG_W = 2;

    // Number of 2-bit digits in an operand of the given width.
    function automatic int ndig(input int width);
        return width / DIG_W;
    endfunction

endpackage

// File: rtl/vedic_seq_mult_vedic2x2.sv
// Combinational 2x2 Vedic (Urdhva-Tiryagbhyam) digit multiplier: vertical and
// crosswise partial products combined with half adders.
module Vedic2x2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);

    logic vert_lo;
    logic cross_a;
    logic cross_b;
    logic vert_hi;
    logic carry_mid;

    assign vert_lo   = a_i[0] & b_i[0];
    assign cross_a   = a_i[1] & b_i[0];
    assign cross_b   = a_i[0] & b_i[1];
    assign vert_hi   = a_i[1] & b_i[1];
    assign carry_mid = cross_a & cross_b;

    assign p_o[0] = vert_lo;
    assign p_o[1] = cross_a ^ cross_b;
    assign p_o[2] = vert_hi ^ carry_mid;
    assign p_o[3] = vert_hi & carry_mid;

endmodule

// File: rtl/vedic_seq_mult.sv
// Sequential WIDTH x WIDTH unsigned multiplier. One 2x2 Vedic cell is reused
// for every digit pair (i, j); each 4-bit partial product is shifted by
// 2*(i+j) and accumulated, one pair per clock, NDIG*NDIG cycles per result.
module vedic_seq_mult
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int NDIG  = ndig(WIDTH);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW    = 2 * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
        $error("vedic_seq_mult: WIDTH must be even and >= 4");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ra_q, ra_d;
    logic [WIDTH-1:0]   rb_q, rb_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [IDX_W-1:0]   j_q, j_d;
    logic [PW-1:0]      product_q, product_d;
    logic               done_q, done_d;

    logic [DIG_W-1:0]   dig_a;
    logic [DIG_W-1:0]   dig_b;
    logic [3:0]         cell_p;
    logic [PW-1:0]      pp_ext;
    logic [IDX_W+1:0]   shamt;
    logic [PW-1:0]      pp_shifted;
    logic [PW-1:0]      acc_sum;
    logic               last_pair;

    // Digit mux: select digit i of ra and digit j of rb for the cell.
    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (i_q == IDX_W'(k)) dig_a = ra_q[k*DIG_W +: DIG_W];
            if (j_q == IDX_W'(k)) dig_b = rb_q[k*DIG_W +: DIG_W];
        end
    end

    Vedic2x2 u_cell (
        .a_i (dig_a),
        .b_i (dig_b),
        .p_o (cell_p)
    );

    // Weight the partial product by 2^(2*(i+j)) and form the running sum.
    always_comb begin
        pp_ext     = {{(PW-4){1'b0}}, cell_p};
        shamt      = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0};
        pp_shifted = pp_ext << shamt;
        acc_sum    = acc_q + pp_shifted;
        last_pair  = (i_q == LAST_IDX) && (j_q == LAST_IDX);
    end

    // FSM, index walk and accumulation next-state logic.
    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        acc_d     = acc_q;
        i_d       = i_q;
        j_d       = j_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_sum;
                if (j_q == LAST_IDX) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
                if (last_pair) begin
                    product_d = acc_sum;
                    done_d    = 1'b1;
                    i_d       = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ra_q      <= '0;
            rb_q      <= '0;
            acc_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            acc_q     <= acc_d;
            i_q       <= i_d;
            j_q       <= j_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_vedic_seq_mult.sv
// Directed bench for vedic_seq_mult (WIDTH=8 and WIDTH=4 instances) with a
// queue of expected products popped on each done pulse.
module tb_vedic_seq_mult;

    logic        clk;
    logic        rst;
    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] product8;
    logic        start4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  product4;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [15:0] exp_q[$];

    vedic_seq_mult #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .product (product8)
    );

    vedic_seq_mult #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start4),
        .a       (a4),
        .b       (b4),
        .busy    (busy4),
        .done    (done4),
        .product (product4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called while busy8 is high; steps until busy drops, then checks the
    // done pulse and product against the scoreboard head.
    task automatic wait_done8(input string tag, input int exp_busy);
        int cnt;
        logic [15:0] e;
        cnt = 0;
        while (busy8 && cnt < 100) begin
            cnt++;
            tick();
        end
        chk({tag, " busy cycles"}, 32'(cnt), 32'(exp_busy));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk({tag, " done"}, {31'b0, done8}, 32'd1);
        chk({tag, " product"}, {16'b0, product8}, {16'b0, e});
    endtask

    task automatic launch8(input logic [7:0] x, input logic [7:0] y);
        a8     = x;
        b8     = y;
        start8 = 1'b1;
        exp_q.push_back(16'(x) * 16'(y));
        tick();
        start8 = 1'b0;
        a8     = 8'hxx;
        b8     = 8'hxx;
    endtask

    initial begin
        int cnt;
        int dones;
        rst    = 1'b0;
        start8 = 1'b0;
        start4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;

        // Reset state
        #3 rst = 1'b1;
        #1;
        chk("reset busy", {31'b0, busy8}, 32'd0);
        chk("reset done", {31'b0, done8}, 32'd0);
        chk("reset product", {16'b0, product8}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 0xFF x 0xFF, single start
        launch8(8'hFF, 8'hFF);
        chk("ff busy after E0", {31'b0, busy8}, 32'd1);
        wait_done8("ff", 16);
        chk("ff product value", {16'b0, product8}, 32'h0000FE01);
        tick();
        chk("ff done single pulse", {31'b0, done8}, 32'd0);
        chk("ff product holds", {16'b0, product8}, 32'h0000FE01);

        // 13 x 11, then zero operand
        launch8(8'd13, 8'd11);
        wait_done8("13x11", 16);
        tick();
        launch8(8'h00, 8'hA5);
        wait_done8("0xA5", 16);
        tick();

        // start held high: back-to-back accepts at E0 and E17
        a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        exp_q.push_back(16'h03A8);
        tick();
        a8 = 8'h80; b8 = 8'h02;
        exp_q.push_back(16'h0100);
        wait_done8("b2b first", 16);
        tick();
        start8 = 1'b0;
        chk("b2b reaccept busy", {31'b0, busy8}, 32'd1);
        chk("b2b done cleared", {31'b0, done8}, 32'd0);
        wait_done8("b2b second", 16);
        tick();
        chk("b2b done single pulse", {31'b0, done8}, 32'd0);

        // start during RUN is ignored
        launch8(8'h07, 8'h09);
        for (int k = 0; k < 4; k++) tick();
        a8 = 8'h55; b8 = 8'h33; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8("ignore start", 11);
        chk("ignore start value", {16'b0, product8}, 32'h0000003F);
        tick();
        chk("ignore start no requeue", {31'b0, busy8}, 32'd0);

        // asynchronous reset mid-run
        a8 = 8'hAB; b8 = 8'hCD; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst busy", {31'b0, busy8}, 32'd0);
        chk("midrst done", {31'b0, done8}, 32'd0);
        chk("midrst product", {16'b0, product8}, 32'd0);
        tick();
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done8 || busy8) dones++;
        end
        chk("midrst no done follows", 32'(dones), 32'd0);
        launch8(8'h0F, 8'h0F);
        wait_done8("after reset", 16);
        chk("after reset value", {16'b0, product8}, 32'h000000E1);
        tick();

        // WIDTH=4 instance: 0xF x 0xE
        a4 = 4'hF; b4 = 4'hE; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        cnt = 0;
        while (busy4 && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("w4 busy cycles", 32'(cnt), 32'd4);
        chk("w4 done", {31'b0, done4}, 32'd1);
        chk("w4 product", {24'b0, product4}, 32'h000000D2);
        tick();
        chk("w4 done single pulse", {31'b0, done4}, 32'd0);

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/vedic_seq_mult.md
# vedic_seq_mult

Sequential WIDTH×WIDTH unsigned multiplier built around a single 2×2 Vedic digit multiplier. On each `start` it latches both operands and walks all 2-bit digit pairs, one pair per clock. Each pair feeds the 2×2 cell, and the cell's 4-bit product is shifted and accumulated into a 2·WIDTH result. It sits upstream of the 2×2 cell, driving its inputs, and downstream of it, consuming its product. This trades area for latency in the arithmetic datapath.

## Interface
- `WIDTH`, 8: operand width in bits; even, ≥ 4. NDIG = WIDTH/2 digits per operand.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `a`  in  WIDTH  multiplicand, unsigned; sampled with an accepted `start`
- `b`  in  WIDTH  multiplier, unsigned; sampled with an accepted `start`
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse when `product` has just updated
- `product`  out  2·WIDTH  last completed result; holds until the next completion

## Operation
- States: IDLE and RUN.
- IDLE, `start`=1 at a clock edge:
  - latch `a`/`b` into `ra`/`rb`
  - clear the accumulator `acc` (2·WIDTH bits)
  - set digit indices i=0, j=0
  - go to RUN
- IDLE, `start`=0: stay in IDLE.
- RUN, each cycle:
  - The cell inputs are digit i of `ra` (bits 2i+1:2i) and digit j of `rb`.
  - The 4-bit cell product is zero-extended to 2·WIDTH and shifted left by 2·(i+j).
  - At the edge, the shifted value is added to `acc`. The sum is taken modulo 2^(2·WIDTH); it never actually overflows.
  - Index advance: j increments; when j=NDIG−1, j wraps to 0 and i increments.
- Last pair (i=j=NDIG−1), at that edge:
  - `product` ← `acc` + shifted partial product
  - `done` ← 1
  - state → IDLE
- `start` during RUN is ignored. Operands are not re-sampled and no request is queued.
- `a`/`b` may change freely after the accepting edge.
- `done` is high only for the cycle after the completing edge.
- A back-to-back request is allowed: `start` sampled while `done`=1 (state is IDLE) is accepted.
- `rst` asserted at any time, including mid-RUN, forces an immediate return:
  - state → IDLE
  - `busy`=0, `done`=0, `product`=0
  - `acc`, i, j, `ra`, `rb` cleared
  - The in-flight operation is discarded and produces no `done`.
- Reset values: `busy`=0, `done`=0, `product`=0.

## Timing
- E0 is the edge that accepts `start`.
- Accumulation edges are E1…E(NDIG²). For WIDTH=8 that is 16 edges.
- `busy` is registered: high after E0, low after E(NDIG²).
- `done` and the new `product` become visible after E(NDIG²). Latency is NDIG² cycles from the accept edge.
- Throughput: one result every NDIG²+1 cycles with `start` held high. With WIDTH=8, the next accept is at E17.
- The 2×2 cell is purely combinational. The only path is from the `ra`/`rb`/i/j registers, through the digit mux, the cell, the shifter and the adder, into `acc`. That whole path must close in one cycle.
- No output is combinationally dependent on any input.

## Structure
- Shared package `vedic_pkg`:
  - state enum (ST_IDLE, ST_RUN)
  - digit width constant DIG_W = 2
  - function `ndig(width)`
- Instantiate the existing `Vedic2x2` cell once for the digit product. Do not add another sub-module.
- Digit mux, shifter, accumulator, index counters and FSM live in `vedic_seq_mult`.
- Add an assertion that WIDTH is even and ≥ 4.

## Test plan
- WIDTH=8, `a`=0xFF, `b`=0xFF, single `start` → `busy` high for 16 cycles; `done` pulses once after E16; `product`=0xFE01.
- WIDTH=8, `a`=13, `b`=11 → `product`=143 (0x008F). Then `a`=0x00, `b`=0xA5 → `product`=0x0000 with `done` asserted.
- `start` held high, operand sequence (0x12, 0x34), (0x80, 0x02) → accepts at E0 and E17; results 0x03A8 then 0x0100; exactly one `done` each.
- Pulse `start` at E5 of a run with `a`=0x07, `b`=0x09 and different operands presented → ignored; result 0x003F at E16.
- Assert `rst` asynchronously at mid-run cycle 8 → `busy`, `done`, `product` all 0 immediately; no `done` follows. A new `start` with 0x0F×0x0F completes to 0x00E1.
- WIDTH=4, `a`=0xF, `b`=0xE → `busy` for 4 cycles; `product`=0xD2.
